// File: rtl/fwht_pkg.sv
// -----------------------------------------------------------------------------
// fwht_pkg
// Shared definitions for the FWHT receive-side reorder buffer.
//   FWHT_N(l)   : frame length for a log2 length l (1 << l)
//   BANK_W      : width of the ping-pong bank select
//   rd_state_e  : read FSM encodings (R_IDLE, R_RUN, R_DRAIN)
// -----------------------------------------------------------------------------
package fwht_pkg;

  localparam int BANK_W = 1;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_e;

  function automatic int FWHT_N(input int l);
    return 1 << l;
  endfunction

endpackage

// File: rtl/fwht_reorder_bank.sv
// -----------------------------------------------------------------------------
// fwht_reorder_bank
// Simple dual-port RAM holding both ping-pong banks: 2*N x WIDTH, the bank
// bit is the address MSB. One write port, one registered read port (1-cycle
// read latency). No reset so it maps onto block RAM.
// Ports:
//   clk      in   clock
//   wr_en    in   write enable
//   wr_addr  in   {bank, index}
//   wr_data  in   write data
//   rd_en    in   read enable (output register updates only when high)
//   rd_addr  in   {bank, index}
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module fwht_reorder_bank
  import fwht_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int L_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [L_WIDTH+BANK_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  input  logic [L_WIDTH+BANK_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]            rd_data
);

  localparam int DEPTH = 2 * FWHT_N(L_WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fwht_reorder.sv
// -----------------------------------------------------------------------------
// fwht_reorder
// Receive-side reorder buffer for the streaming FWHT core. Each incoming
// coefficient is written into a ping-pong bank at its sequency index; a
// complete bank is replayed in index order 0..N-1 over AXI-Stream with tlast.
// Optional build macro: FWHT_REORDER_SCALE_EN -- output = coefficient >>> L_WIDTH
// (1/N normalisation); undefined -> coefficient passed unmodified.
// Ports:
//   ACLK, ARESET   clock, synchronous active-high reset
//   s_axis_tdata   coefficient in        s_axis_tvalid  coefficient valid
//   s_index        sequency index        s_axis_tready  write bank free (advisory)
//   m_axis_tdata   reordered coefficient m_axis_tvalid  output valid
//   m_axis_tready  downstream ready      m_axis_tlast   beat carrying index N-1
//   o_overflow     sticky: sample dropped because no bank was free
// Handshake: a beat transfers on any edge where m_axis_tvalid & m_axis_tready;
// while tvalid=1 and tready=0, tdata/tlast hold. The input side cannot stall:
// s_axis_tvalid samples are taken or dropped, never held off.
// -----------------------------------------------------------------------------
module fwht_reorder
  import fwht_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int L_WIDTH = 12
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic [L_WIDTH-1:0] s_index,
  output logic               s_axis_tready,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               o_overflow
);

  // ---------------- state ----------------
  logic [L_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic               ovf_q, ovf_d;
  rd_state_e          rd_state_q, rd_state_d;
  logic [L_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic               rd_vld_q, rd_vld_d;     // RAM read in flight
  logic               rd_last_q, rd_last_d;   // in-flight read is index N-1
  logic [1:0][WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]         fifo_last_q, fifo_last_d;
  logic               fifo_wp_q, fifo_wp_d;
  logic               fifo_rp_q, fifo_rp_d;
  logic [1:0]         fifo_cnt_q, fifo_cnt_d;

  // ---------------- combinational ----------------
  logic               wr_en, set_full, clr_full;
  logic               rd_issue, can_issue, fifo_pop, last_accept;
  logic [1:0]         fifo_occ;
  logic [WIDTH-1:0]   ram_rdata, push_data;

  fwht_reorder_bank #(.WIDTH(WIDTH), .L_WIDTH(L_WIDTH)) u_bank (
    .clk     (ACLK),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_q, s_index}),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank_q, rd_addr_q}),
    .rd_data (ram_rdata)
  );

  // Write side: frame boundary is the sample count, not the index values.
  always_comb begin
    wr_en     = s_axis_tvalid & ~full_q[wr_bank_q];
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    set_full  = 1'b0;
    ovf_d     = ovf_q | (s_axis_tvalid & full_q[wr_bank_q]);
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '1) begin
        wr_bank_d = ~wr_bank_q;
        set_full  = 1'b1;
      end
    end
  end

  // Output FIFO bookkeeping. A read may issue only if the FIFO will still
  // have room when its data lands next cycle, counting the beat already in
  // flight and the beat leaving now.
  assign fifo_pop    = (fifo_cnt_q != 2'd0) & m_axis_tready;
  assign last_accept = fifo_pop & fifo_last_q[fifo_rp_q];
  assign fifo_occ    = fifo_cnt_q + {1'b0, rd_vld_q} - {1'b0, fifo_pop};
  assign can_issue   = (fifo_occ < 2'd2);

  // Read FSM: next state. IDLE issues address 0 on the way into RUN so the
  // first beat is valid two edges after the frame's last write.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (full_q[rd_bank_q] && can_issue) rd_state_d = R_RUN;
      R_RUN:   if (can_issue && (rd_addr_q == '1)) rd_state_d = R_DRAIN;
      R_DRAIN: if (last_accept) rd_state_d = full_q[~rd_bank_q] ? R_RUN : R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM: outputs.
  always_comb begin
    rd_issue = 1'b0;
    clr_full = 1'b0;
    case (rd_state_q)
      R_IDLE:  rd_issue = full_q[rd_bank_q] & can_issue;
      R_RUN:   rd_issue = can_issue;
      R_DRAIN: clr_full = last_accept;
      default: ;
    endcase
  end

`ifdef FWHT_REORDER_SCALE_EN
  assign push_data = $signed(ram_rdata) >>> L_WIDTH;
`else
  assign push_data = ram_rdata;
`endif

  // Read datapath, bank flags and FIFO. Writer sets and reader clears always
  // target different banks, so both may act on the same edge.
  always_comb begin
    rd_addr_d   = rd_issue ? rd_addr_q + 1'b1 : rd_addr_q;
    rd_vld_d    = rd_issue;
    rd_last_d   = rd_issue & (rd_addr_q == '1);
    rd_bank_d   = clr_full ? ~rd_bank_q : rd_bank_q;
    full_d      = full_q;
    if (clr_full) full_d[rd_bank_q] = 1'b0;
    if (set_full) full_d[wr_bank_q] = 1'b1;

    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_pop ? ~fifo_rp_q : fifo_rp_q;
    if (rd_vld_q) begin
      fifo_data_d[fifo_wp_q] = push_data;
      fifo_last_d[fifo_wp_q] = rd_last_q;
      fifo_wp_d              = ~fifo_wp_q;
    end
    fifo_cnt_d = fifo_cnt_q + {1'b0, rd_vld_q} - {1'b0, fifo_pop};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      ovf_q       <= 1'b0;
      rd_state_q  <= R_IDLE;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      fifo_data_q <= '0;
      fifo_last_q <= 2'b00;
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rd_state_q  <= rd_state_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  assign s_axis_tready = ~full_q[wr_bank_q];
  assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign m_axis_tdata  = fifo_data_q[fifo_rp_q];
  assign m_axis_tlast  = m_axis_tvalid & fifo_last_q[fifo_rp_q];
  assign o_overflow    = ovf_q;

endmodule
